// File: rtl/conv_encoder_if.sv
// Input and output handshake bundle of the rate-1/2 convolutional encoder.
interface conv_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic [1:0] out_mask;
  logic       out_last;
  logic       busy;

  // Driver/consumer side (bit source and symbol sink)
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_mask, out_last, busy
  );

  // Encoder side
  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_mask, out_last, busy
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with zero-tail termination.
// Optional rate-2/3 puncturing mask is enabled by defining CONV_PUNCT_EN.
module conv_encoder #(
  parameter int unsigned    K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input logic           clk,
  input logic           rst,
  conv_encoder_if.slave enc
);

  localparam int unsigned CntW = $clog2(K);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e          state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;
  logic [CntW-1:0] tail_cnt_q, tail_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      out_sym_q, out_sym_d;
  logic [1:0]      out_mask_q, out_mask_d;
  logic            out_last_q, out_last_d;

  logic            slot_free;
  logic            in_ready;
  logic            busy;
  logic            accept;
  logic            gen;
  logic            b;
  logic [K-1:0]    u;
  logic [1:0]      mask_now;

`ifdef CONV_PUNCT_EN
  logic phase_q, phase_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_mask_q  <= 2'b11;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef CONV_PUNCT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  always_comb begin : next_state
    state_d     = state_q;
    sr_d        = sr_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;

    accept = enc.in_valid && in_ready;
    gen    = accept || ((state_q == StTail) && slot_free);
    b      = (state_q == StTail) ? 1'b0 : enc.in_bit;
    u      = {b, sr_q};

`ifdef CONV_PUNCT_EN
    mask_now = phase_q ? 2'b01 : 2'b11;
`else
    mask_now = 2'b11;
`endif

    if (gen) begin
      out_valid_d = 1'b1;
      out_sym_d   = {^(u & G1), ^(u & G0)};
      out_mask_d  = mask_now;
      out_last_d  = 1'b0;
      sr_d        = {b, sr_q[K-2:1]};
    end else if (enc.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle, StData: begin
        if (accept) begin
          if (enc.in_last) begin
            state_d    = StTail;
            tail_cnt_d = CntW'(K - 1);
          end else begin
            state_d = StData;
          end
        end
      end
      StTail: begin
        if (slot_free) begin
          tail_cnt_d = tail_cnt_q - CntW'(1);
          // The last tail symbol flushes the register back to zero
          if (tail_cnt_q == CntW'(1)) begin
            out_last_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef CONV_PUNCT_EN
    phase_d = gen ? ~phase_q : phase_q;
    if ((state_d == StIdle) && (state_q != StIdle)) begin
      phase_d = 1'b0;
    end
`endif
  end

  always_comb begin : outputs
    slot_free = !out_valid_q || enc.out_ready;
    in_ready  = ((state_q == StIdle) || (state_q == StData)) && slot_free && !rst;
    busy      = (state_q == StData) || (state_q == StTail);
  end

  assign enc.in_ready  = in_ready;
  assign enc.busy      = busy;
  assign enc.out_valid = out_valid_q;
  assign enc.out_sym   = out_sym_q;
  assign enc.out_mask  = out_mask_q;
  assign enc.out_last  = out_last_q;

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2 feed-forward convolutional encoder. It is the transmit-side counterpart of the team's Viterbi decoder, whose add-compare-select datapath uses the max_pos comparator.
- Accepts a framed serial bit stream and emits one 2-bit code symbol per input bit.
- At end of frame it appends K-1 zero tail bits, so the decoder trellis terminates in state 0.
- Valid/ready handshakes on both sides.

Parameters:
K, 3, constraint length (3..9); the shift register holds K-1 bits.
G0, 3'b111 (octal 7), generator polynomial for symbol bit 0; width K, MSB taps the current input bit.
G1, 3'b101 (octal 5), generator polynomial for symbol bit 1; width K, MSB taps the current input bit.

Ports:
clk        in   1  system clock; all state updates on the rising edge
rst        in   1  synchronous, active-high reset
in_valid   in   1  in_bit and in_last are valid
in_ready   out  1  encoder accepts an input bit this cycle
in_bit     in   1  information bit
in_last    in   1  marks the final information bit of the frame
out_valid  out  1  out_sym, out_mask and out_last are valid
out_ready  in   1  downstream accepts the symbol
out_sym    out  2  [0] = parity of G0 taps, [1] = parity of G1 taps
out_mask   out  2  per-bit transmit mask; 2'b11 unless CONV_PUNCT_EN is defined
out_last   out  1  marks the final (tail) symbol of the frame
busy       out  1  high in DATA or TAIL state

Behaviour:
- Reset: rst is sampled on clk only (synchronous, active-high).
  - sr = 0, state = IDLE, tail_cnt = 0.
  - out_valid = 0, out_sym = 2'b00, out_mask = 2'b11, out_last = 0, busy = 0.
  - in_ready = 0 during the reset cycle.
- Encoder core:
  - u = {b, sr[K-2:0]}, where b is the current input bit (or 0 during tail) and sr[K-2] is the most recent past bit.
  - out_sym[j] = XOR-reduce(u & Gj).
  - On each generated symbol, sr <= {b, sr[K-2:1]}.
- Output register: a single stage. A slot is free when !out_valid || out_ready.
  - A symbol is loaded only into a free slot; out_valid = 1 in the cycle after loading, so latency is 1 cycle.
  - While out_valid && !out_ready, out_sym, out_mask and out_last hold stable.
  - Loading and draining in the same cycle sustains 1 symbol per clk.
- in_ready = (state == IDLE || state == DATA) && slot free && !rst. Combinational; it depends on out_ready.
- FSM:
  - IDLE, sr = 0. An accepted bit generates a symbol. It moves to DATA if in_last = 0, or to TAIL with tail_cnt = K-1 if in_last = 1.
  - DATA. An accepted bit generates a symbol; on in_last = 1 it moves to TAIL with tail_cnt = K-1.
  - TAIL. in_ready = 0. Each cycle with a free slot generates a symbol with b = 0 and decrements tail_cnt. The symbol generated when tail_cnt == 1 carries out_last = 1, and the FSM returns to IDLE in the same edge; sr is then 0.
- out_last is never set on data symbols.
- Back-to-back frames: IDLE accepts the next frame's first bit in the cycle immediately after the final tail symbol is loaded.
- in_valid = 0 in DATA: the FSM waits indefinitely and sr holds.
- Reset mid-frame: the partial frame and the pending symbol are discarded; no out_last is emitted.
- Symbols per frame = N information bits + K-1 tail bits, with N >= 1.

Optional Feature:
Macro CONV_PUNCT_EN.
- Defined:
  - Rate-2/3 puncturing via out_mask. A phase bit toggles per generated symbol and clears on IDLE entry and on reset.
  - Phase 0: out_mask = 2'b11. Phase 1: out_mask = 2'b01, which deletes out_sym[1].
  - Tail symbols continue the phase sequence.
  - out_sym is always computed unpunctured.
- Undefined: no phase register; out_mask is tied to 2'b11.

Test Plan:
1. K=3, (7,5); frame 1,0,1,1 (last on 4th), out_ready = 1 -> (out_sym[0], out_sym[1]) = 11, 10, 00, 01, 01, 11; out_last only on the 6th symbol; busy drops after it.
2. Same frame, out_ready low for 3 cycles at symbol 2 -> symbol 10 holds stable, in_ready = 0 while stalled, final sequence unchanged.
3. Single-bit frame: in_bit = 1, in_last = 1 from IDLE -> 11, 10, 11; out_last on the 3rd; next frame's first bit accepted the following cycle.
4. rst asserted after 2 data bits -> out_valid = 0, busy = 0, sr = 0 next cycle; a new frame 1 encodes as a fresh frame (11, 10, 11).
5. CONV_PUNCT_EN defined, frame 1,0,1,1 -> out_mask = 11, 01, 11, 01, 11, 01; phase restarts at 11 on the next frame.
6. Continuous random frames, in_valid and out_ready randomized -> a reference model matches every symbol, no symbol lost or duplicated, each frame ends with exactly K-1 tail symbols.
